// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB encodings (HTRANS, HRESP, HSIZE, HBURST) and the SRAM responder FSM state type.
// Also used by ahbmaster so both sides agree on the bus constants.
package ahb_sram_slave_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_WAIT = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slv_state_e;

endpackage

// File: rtl/ahb_sram_mem.sv
// MEM_DEPTH x DATA_WIDTH word memory split into byte lanes: one registered read port,
// one byte-strobed write port. Read is read-first with respect to a same-cycle write.
module ahb_sram_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 128,
  localparam int NB        = DATA_WIDTH / 8,
  localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [NB-1:0]         wr_strb,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] lane_mem [MEM_DEPTH];
    logic [7:0] rd_byte_reg;

    // Array contents are deliberately not reset so the lane maps onto block RAM.
    always_ff @(posedge HCLK) begin
      if (wr_en && wr_strb[gi]) begin
        lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
      end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        rd_byte_reg <= '0;
      end else if (rd_en) begin
        rd_byte_reg <= lane_mem[rd_idx];
      end
    end

    assign rd_data[gi*8 +: 8] = rd_byte_reg;
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB SRAM responder with OKAY/ERROR responses and write-to-read forwarding.
// Define AHBSLV_WAIT_EN to insert WAIT_CYCLES wait states on every good transfer.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 128,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELx,
  input  logic [AW-1:0]         HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY_IN,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int NB      = DATA_WIDTH / 8;
  localparam int LOG2_NB = $clog2(NB);
  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam logic [AW:0] BYTE_SIZE = (AW+1)'(MEM_DEPTH * NB);

`ifdef AHBSLV_WAIT_EN
  localparam slv_state_e GOOD_ST = ST_WAIT;
`else
  localparam slv_state_e GOOD_ST = ST_DATA;
`endif

  slv_state_e state_reg, state_next;

  logic                  accept;
  logic                  acc_err;
  logic                  rd_launch;
  logic                  commit;
  logic [IDX_W-1:0]      acc_idx;
  logic [NB-1:0]         acc_strb;
  logic [AW-1:0]         size_mask;
  int                    acc_off;
  int                    acc_len;

  logic                  wr_pend_reg;
  logic [IDX_W-1:0]      wr_idx_reg;
  logic [NB-1:0]         wr_strb_reg;
  logic                  fwd_reg;
  logic [NB-1:0]         fwd_strb_reg;
  logic [DATA_WIDTH-1:0] fwd_data_reg;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Address-phase decode.
  assign accept    = HSELx && HREADY_IN &&
                     (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign size_mask = (AW'(1) << HSIZE) - AW'(1);
  assign acc_err   = (HSIZE > 3'(LOG2_NB)) ||
                     (|(HADDR & size_mask)) ||
                     ({1'b0, HADDR} >= BYTE_SIZE);
  assign acc_idx   = HADDR[LOG2_NB +: IDX_W];
  assign acc_off   = int'(HADDR[LOG2_NB-1:0]);
  assign acc_len   = 1 << HSIZE;
  assign rd_launch = accept && !acc_err && !HWRITE;
  assign commit    = (state_reg == ST_DATA) && wr_pend_reg;

  for (genvar gi = 0; gi < NB; gi++) begin : g_strb
    assign acc_strb[gi] = (gi >= acc_off) && (gi < acc_off + acc_len);
  end

`ifdef AHBSLV_WAIT_EN
  logic [2:0] wait_cnt_reg, wait_cnt_next;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT};
`else
  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, 3'(WAIT_CYCLES)};
`endif

  always_comb begin
    state_next = state_reg;
`ifdef AHBSLV_WAIT_EN
    wait_cnt_next = wait_cnt_reg;
`endif
    case (state_reg)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept) begin
          state_next = acc_err ? ST_ERR1 : GOOD_ST;
`ifdef AHBSLV_WAIT_EN
          wait_cnt_next = 3'(WAIT_CYCLES);
`endif
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ERR1: state_next = ST_ERR2;
`ifdef AHBSLV_WAIT_EN
      ST_WAIT: begin
        if (wait_cnt_reg <= 3'd1) begin
          state_next = ST_DATA;
        end else begin
          wait_cnt_next = wait_cnt_reg - 3'd1;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  assign HREADYOUT = !((state_reg == ST_ERR1) || (state_reg == ST_WAIT));
  assign HRESP     = ((state_reg == ST_ERR1) || (state_reg == ST_ERR2)) ? HRESP_ERROR
                                                                         : HRESP_OKAY;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg    <= ST_IDLE;
      wr_pend_reg  <= 1'b0;
      wr_idx_reg   <= '0;
      wr_strb_reg  <= '0;
      fwd_reg      <= 1'b0;
      fwd_strb_reg <= '0;
      fwd_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        wr_pend_reg <= !acc_err && HWRITE;
        wr_idx_reg  <= acc_idx;
        wr_strb_reg <= acc_strb;
      end else if (state_reg == ST_DATA) begin
        wr_pend_reg <= 1'b0;
      end
      // A read launched on the edge that commits a write to the same word sees the
      // pre-write RAM contents; remember the committing bytes so they can be merged.
      if (rd_launch) begin
        fwd_reg      <= commit && (wr_idx_reg == acc_idx);
        fwd_strb_reg <= wr_strb_reg;
        fwd_data_reg <= HWDATA;
      end
    end
  end

  ahb_sram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .rd_en   (rd_launch),
    .rd_idx  (acc_idx),
    .rd_data (mem_rdata),
    .wr_en   (commit),
    .wr_idx  (wr_idx_reg),
    .wr_strb (wr_strb_reg),
    .wr_data (HWDATA)
  );

  for (genvar gi = 0; gi < NB; gi++) begin : g_rdata
    assign HRDATA[gi*8 +: 8] = (fwd_reg && fwd_strb_reg[gi]) ? fwd_data_reg[gi*8 +: 8]
                                                              : mem_rdata[gi*8 +: 8];
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: pipelined AHB master, byte-level reference memory,
// scoreboard of expected responses popped as each data phase completes.
module tb_ahb_sram_slave;
  import ahb_sram_slave_pkg::*;

  localparam int WC = 2;
`ifdef AHBSLV_WAIT_EN
  localparam int EXP_WAIT = WC;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSELx = 1'b0;
  logic [31:0] HADDR = '0;
  logic        HWRITE = 1'b0;
  logic [1:0]  HTRANS = HTRANS_IDLE;
  logic [2:0]  HSIZE = HSIZE_WORD;
  logic [2:0]  HBURST = HBURST_SINGLE;
  logic [3:0]  HPROT = 4'h3;
  logic [31:0] HWDATA = '0;
  logic        HREADY_IN;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  assign HREADY_IN = HREADYOUT;

  ahb_sram_slave #(
    .AW(32), .DATA_WIDTH(32), .MEM_DEPTH(128), .WAIT_CYCLES(WC)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELx(HSELx), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY_IN(HREADY_IN), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [1:0]  trans;
    logic [2:0]  burst;
  } op_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic        err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  op_t        ops[$];
  exp_t       sb[$];
  logic [7:0] model [0:511];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                     input logic [31:0] wd, input logic [1:0] tr, input logic [2:0] bu);
    op_t o;
    o.addr = a; o.wr = wr; o.size = sz; o.wdata = wd; o.trans = tr; o.burst = bu;
    ops.push_back(o);
  endtask

  // Reference: a good write updates the byte model on the lanes selected by the address.
  task automatic predict(input op_t o, output exp_t e);
    int          nb;
    logic [31:0] w;
    nb = 1 << o.size;
    e.addr  = o.addr;
    e.wr    = o.wr;
    e.err   = (o.size > 3'd2) || ((o.addr % nb) != 0) || (o.addr >= 32'd512);
    e.waits = e.err ? 1 : EXP_WAIT;
    e.rdata = '0;
    if (!e.err) begin
      w = o.addr & ~32'h3;
      if (o.wr) begin
        for (int b = 0; b < nb; b++) model[o.addr + b] = o.wdata[8*((o.addr % 4) + b) +: 8];
      end else begin
        e.rdata = {model[w+3], model[w+2], model[w+1], model[w]};
      end
    end
  endtask

  task automatic run_ops();
    op_t  cur;
    exp_t e;
    logic ready;
    int   lows = 0;
    while (ops.size() > 0 || sb.size() > 0) begin
      if (ops.size() > 0) begin
        HSELx = 1'b1; HADDR = ops[0].addr; HWRITE = ops[0].wr; HSIZE = ops[0].size;
        HTRANS = ops[0].trans; HBURST = ops[0].burst;
      end else begin
        HSELx = 1'b0; HTRANS = HTRANS_IDLE; HBURST = HBURST_SINGLE;
      end
      @(negedge HCLK);
      ready = HREADYOUT;
      if (sb.size() > 0) begin
        e = sb[0];
        if (!ready) begin
          lows++;
          if (e.err) chk($sformatf("err1_resp@%h", e.addr), 32'(HRESP), 32'(HRESP_ERROR));
          if (lows > 20) begin
            total++; bad++;
            $error("FAIL timeout@%h: observed=%0d low cycles expected=%0d", e.addr, lows, e.waits);
            void'(sb.pop_front());
            lows = 0;
          end
        end else begin
          e = sb.pop_front();
          chk($sformatf("resp@%h", e.addr), 32'(HRESP), e.err ? 32'(HRESP_ERROR) : 32'(HRESP_OKAY));
          if (!e.wr && !e.err) chk($sformatf("rdata@%h", e.addr), HRDATA, e.rdata);
          chk($sformatf("waits@%h", e.addr), 32'(lows), 32'(e.waits));
          $display("txn %s @%h resp=%0d rdata=%h waits=%0d", e.wr ? "wr" : "rd", e.addr,
                   HRESP, HRDATA, lows);
          lows = 0;
        end
      end
      @(posedge HCLK); #1;
      if (ready && ops.size() > 0) begin
        cur = ops.pop_front();
        HWDATA = cur.wdata;
        if (cur.trans[1]) begin
          predict(cur, e);
          sb.push_back(e);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'(HRESP_OKAY));
    chk("rst_hrdata", HRDATA, 32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Word write then read, separated by IDLE
    add(32'h10, 1'b1, HSIZE_WORD, 32'hDEADBEEF, HTRANS_NONSEQ, HBURST_SINGLE);
    add(32'h00, 1'b0, HSIZE_WORD, 32'h0, HTRANS_IDLE, HBURST_SINGLE);
    add(32'h10, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
    run_ops();

    // Back-to-back write/read of the same word (forwarding)
    add(32'h18, 1'b1, HSIZE_WORD, 32'h12345678, HTRANS_NONSEQ, HBURST_SINGLE);
    add(32'h18, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
    run_ops();

    // Byte merge into an existing word, read immediately after
    add(32'h10, 1'b1, HSIZE_WORD, 32'h11223344, HTRANS_NONSEQ, HBURST_SINGLE);
    add(32'h11, 1'b1, HSIZE_BYTE, 32'h0000AA00, HTRANS_NONSEQ, HBURST_SINGLE);
    add(32'h10, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
    run_ops();

    // Error cases must not disturb memory; the following transfer is honoured
    add(32'h200, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
    add(32'h02, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
    add(32'h12, 1'b1, HSIZE_WORD, 32'hFFFFFFFF, HTRANS_NONSEQ, HBURST_SINGLE);
    add(32'h10, 1'b1, HSIZE_DWORD, 32'hFFFFFFFF, HTRANS_NONSEQ, HBURST_SINGLE);
    add(32'h10, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
    add(32'h1A, 1'b1, HSIZE_HALF, 32'hBEEF0000, HTRANS_NONSEQ, HBURST_SINGLE);
    add(32'h00, 1'b0, HSIZE_WORD, 32'h0, HTRANS_IDLE, HBURST_SINGLE);
    add(32'h18, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
    run_ops();

    // INCR4 write burst then INCR4 read burst
    for (int i = 0; i < 4; i++)
      add(32'h20 + 32'(4*i), 1'b1, HSIZE_WORD, 32'(i + 1),
          (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, HBURST_INCR4);
    for (int i = 0; i < 4; i++)
      add(32'h20 + 32'(4*i), 1'b0, HSIZE_WORD, 32'h0,
          (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, HBURST_INCR4);
    run_ops();

    // Reset during the data phase of a write: the write must be lost
    HSELx = 1'b1; HADDR = 32'h20; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
    HTRANS = HTRANS_NONSEQ; HBURST = HBURST_SINGLE;
    @(posedge HCLK); #1;
    HSELx = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 32'h55555555;
    @(negedge HCLK);
    chk("pre_rst_hreadyout", 32'(HREADYOUT), (EXP_WAIT > 0) ? 32'd0 : 32'd1);
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("mid_rst_hresp", 32'(HRESP), 32'(HRESP_OKAY));
    chk("mid_rst_hrdata", HRDATA, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    add(32'h20, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE);
    run_ops();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
